// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: debounced buttons drive an IDLE/RUNNING/LAP/PAUSED FSM that gates the
// 100 Hz divider and turns its square output into single-cycle count ticks.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int DB_W            = 14
) (
  input  logic       clk_in,
  input  logic       res,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       div_clk,
  output logic       div_ena,
  output logic       div_res_n,
  output logic       tick,
  output logic       cnt_clear,
  output logic       display_freeze,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_LAP   = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // bit 0 lap, bit 1 start_stop, bit 2 clear
  logic [2:0] btn_raw;
  logic [2:0] btn_s1;
  logic [2:0] btn_s2;
  logic [2:0] press;

  assign btn_raw = {btn_clear, btn_start_stop, btn_lap};

  always_ff @(posedge clk_in or posedge res) begin
    if (res) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic [DB_W-1:0] cnt;
    logic            lvl;

    always_ff @(posedge clk_in or posedge res) begin
      if (res) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (btn_s2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    // Event taken from the flip itself so the FSM moves in the same edge the level is accepted.
    assign press[i] = btn_s2[i] & ~lvl & (cnt == DB_LAST);
  end

  logic   press_lap;
  logic   press_ss;
  logic   press_clr;
  state_t state_q;
  state_t state_nxt;
  logic   clr_nxt;

  assign press_lap = press[0];
  assign press_ss  = press[1];
  assign press_clr = press[2];

  always_comb begin
    state_nxt = state_q;
    clr_nxt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press_clr)     clr_nxt   = 1'b1;
        else if (press_ss) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (press_ss)       state_nxt = S_PAUSE;
        else if (press_lap) state_nxt = S_LAP;
      end
      S_LAP: begin
        if (press_ss)       state_nxt = S_PAUSE;
        else if (press_lap) state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (press_clr) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
        end else if (press_ss) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge res) begin
    if (res) begin
      state_q        <= S_IDLE;
      div_ena        <= 1'b0;
      div_res_n      <= 1'b0;
      display_freeze <= 1'b0;
      cnt_clear      <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      div_ena        <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
      div_res_n      <= (state_nxt != S_IDLE);
      display_freeze <= (state_nxt == S_LAP);
      cnt_clear      <= clr_nxt;
    end
  end

  assign state = state_q;

  logic div_s1;
  logic div_s2;
  logic div_hist;

  // History tracks div_clk in every state so a rise seen while paused is consumed, not deferred.
  always_ff @(posedge clk_in or posedge res) begin
    if (res) begin
      div_s1   <= 1'b0;
      div_s2   <= 1'b0;
      div_hist <= 1'b0;
      tick     <= 1'b0;
    end else begin
      div_s1   <= div_clk;
      div_s2   <= div_s1;
      div_hist <= div_s2;
      tick     <= div_s2 & ~div_hist & ((state_q == S_RUN) || (state_q == S_LAP));
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with 4-cycle debounce and a 20-cycle div_clk.
module tb_stopwatch_ctrl;

  logic       clk_in = 1'b0;
  logic       res = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic       div_clk = 1'b0;
  logic       div_ena;
  logic       div_res_n;
  logic       tick;
  logic       cnt_clear;
  logic       display_freeze;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk_in(clk_in),
    .res(res),
    .btn_start_stop(btn_start_stop),
    .btn_lap(btn_lap),
    .btn_clear(btn_clear),
    .div_clk(div_clk),
    .div_ena(div_ena),
    .div_res_n(div_res_n),
    .tick(tick),
    .cnt_clear(cnt_clear),
    .display_freeze(display_freeze),
    .state(state)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // div_clk rises on the falling edge where cyc wraps to a multiple of 20, so ticks land at cyc%20==3.
  initial forever begin
    @(negedge clk_in);
    div_clk = ((cyc % 20) < 10);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic tick_window(input int n, input bit en, input string tag);
    int bad;
    int seen;
    int want;
    bad = 0; seen = 0; want = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      if (tick === 1'b1) seen++;
      if (en && (cyc % 20 == 3)) want++;
      if (tick !== (en && (cyc % 20 == 3))) bad++;
    end
    chk({tag, "_count"}, 8'(seen), 8'(want));
    chk({tag, "_misplaced"}, 8'(bad), 8'd0);
  endtask

  initial begin
    int clr_seen;

    wait_cyc(3);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_res_n", 8'(div_res_n), 8'd0);
    res = 1'b0;
    tick_window(100, 1'b0, "idle_tick");
    chk("idle_state", 8'(state), 8'd0);
    chk("idle_ena", 8'(div_ena), 8'd0);
    chk("idle_res_n", 8'(div_res_n), 8'd0);

    // start: raw edge then 6 edges to RUNNING
    btn_start_stop = 1'b1;
    wait_cyc(5);
    chk("start_early", 8'(state), 8'd0);
    wait_cyc(1);
    chk("start_state", 8'(state), 8'd1);
    chk("start_res_n", 8'(div_res_n), 8'd1);
    chk("start_ena", 8'(div_ena), 8'd1);
    wait_cyc(4);
    btn_start_stop = 1'b0;
    wait_cyc(2);
    tick_window(60, 1'b1, "run_tick");

    btn_lap = 1'b1;
    wait_cyc(6);
    chk("lap_state", 8'(state), 8'd2);
    chk("lap_freeze", 8'(display_freeze), 8'd1);
    chk("lap_ena", 8'(div_ena), 8'd1);
    wait_cyc(4);
    btn_lap = 1'b0;
    wait_cyc(2);
    tick_window(40, 1'b1, "lap_tick");

    btn_lap = 1'b1;
    wait_cyc(6);
    chk("unlap_state", 8'(state), 8'd1);
    chk("unlap_freeze", 8'(display_freeze), 8'd0);
    wait_cyc(4);
    btn_lap = 1'b0;
    wait_cyc(8);

    btn_start_stop = 1'b1;
    wait_cyc(6);
    chk("pause_state", 8'(state), 8'd3);
    chk("pause_ena", 8'(div_ena), 8'd0);
    wait_cyc(4);
    btn_start_stop = 1'b0;
    wait_cyc(2);
    tick_window(40, 1'b0, "pause_tick");

    // clear beats start_stop in PAUSED
    btn_clear = 1'b1;
    btn_start_stop = 1'b1;
    wait_cyc(5);
    chk("clr_early", 8'(state), 8'd3);
    chk("clr_early_pulse", 8'(cnt_clear), 8'd0);
    wait_cyc(1);
    chk("clr_state", 8'(state), 8'd0);
    chk("clr_pulse", 8'(cnt_clear), 8'd1);
    chk("clr_res_n", 8'(div_res_n), 8'd0);
    wait_cyc(1);
    chk("clr_pulse_end", 8'(cnt_clear), 8'd0);
    chk("clr_ss_discard", 8'(state), 8'd0);
    wait_cyc(3);
    btn_clear = 1'b0;
    btn_start_stop = 1'b0;
    wait_cyc(8);

    // 2-cycle glitches on every button
    clr_seen = 0;
    btn_clear = 1'b1; btn_start_stop = 1'b1; btn_lap = 1'b1;
    wait_cyc(2);
    btn_clear = 1'b0; btn_start_stop = 1'b0; btn_lap = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (cnt_clear === 1'b1) clr_seen++;
    end
    chk("glitch_state", 8'(state), 8'd0);
    chk("glitch_clear", 8'(clr_seen), 8'd0);

    btn_start_stop = 1'b1;
    wait_cyc(6);
    chk("restart_state", 8'(state), 8'd1);
    wait_cyc(4);
    btn_start_stop = 1'b0;
    wait_cyc(8);

    clr_seen = 0;
    btn_clear = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (cnt_clear === 1'b1) clr_seen++;
    end
    chk("run_clr_state", 8'(state), 8'd1);
    chk("run_clr_pulse", 8'(clr_seen), 8'd0);
    btn_clear = 1'b0;
    wait_cyc(8);

    // reset mid-RUNNING with start_stop held, before it qualifies
    btn_start_stop = 1'b1;
    wait_cyc(3);
    res = 1'b1;
    #1;
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_ena", 8'(div_ena), 8'd0);
    chk("arst_res_n", 8'(div_res_n), 8'd0);
    chk("arst_tick", 8'(tick), 8'd0);
    chk("arst_clear", 8'(cnt_clear), 8'd0);
    chk("arst_freeze", 8'(display_freeze), 8'd0);
    wait_cyc(3);
    res = 1'b0;
    wait_cyc(5);
    chk("held_early", 8'(state), 8'd0);
    wait_cyc(1);
    chk("held_state", 8'(state), 8'd1);
    chk("held_ena", 8'(div_ena), 8'd1);
    btn_start_stop = 1'b0;
    wait_cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
